// File: rtl/elite_7seg_spi_rx.sv
// SPI mode-0 slave that receives 16-bit {address, data} display frames and
// drives the Elite_7Seg digit-select/display-word/set-strobe interface.
`timescale 1ns/1ps

module elite_7seg_spi_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_MAX    = 5
) (
    input  logic       CLOCK_50,
    input  logic       Reset_SPI,
    input  logic       SPI_SCLK,
    input  logic       SPI_MOSI,
    input  logic       SPI_CS_n,
    output logic       SPI_MISO,
    output logic [2:0] Elite_7Seg_Digit_Sel,
    output logic [7:0] Elite_7Seg_Disp_Word,
    output logic       Elite_7Seg_Set_Flag,
    output logic       SPI_Frame_Err,
    output logic [7:0] SPI_Frame_Cnt
);

    typedef enum logic [1:0] {
        WAIT_HIGH,
        IDLE,
        SHIFT,
        COMMIT
    } stateT;

    localparam logic [7:0] ADDR_LIMIT = 8'(ADDR_MAX);

    logic [SYNC_STAGES-1:0] sclkSync_q, mosiSync_q, csSync_q, settle_q;
    logic                   sclkRise_q, sclkFall_q, csRise_q, csFall_q;
    logic                   csS, mosiS, csSettledHigh;

    stateT       state_q, state_d;
    logic [4:0]  bitCnt_q, bitCnt_d;
    logic        overrun_q, overrun_d;
    logic [15:0] rxShift_q, rxShift_d;
    logic [15:0] txShift_q, txShift_d;
    logic        miso_q, miso_d;
    logic [2:0]  digitSel_q, digitSel_d;
    logic [7:0]  dispWord_q, dispWord_d;
    logic        setFlag_q, setFlag_d;
    logic        frameErr_q, frameErr_d;
    logic [7:0]  frameCnt_q, frameCnt_d;

    // Edge pulses are registered so each one lines up with the cycle in
    // which the last synchronizer stage takes its new value.
    always_ff @(posedge CLOCK_50) begin
        if (!Reset_SPI) begin
            sclkSync_q <= '0;
            mosiSync_q <= '0;
            csSync_q   <= '1;
            settle_q   <= '0;
            sclkRise_q <= 1'b0;
            sclkFall_q <= 1'b0;
            csRise_q   <= 1'b0;
            csFall_q   <= 1'b0;
        end else begin
            sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], SPI_SCLK};
            mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], SPI_MOSI};
            csSync_q   <= {csSync_q[SYNC_STAGES-2:0], SPI_CS_n};
            settle_q   <= {settle_q[SYNC_STAGES-2:0], 1'b1};
            sclkRise_q <= sclkSync_q[SYNC_STAGES-2] & ~sclkSync_q[SYNC_STAGES-1];
            sclkFall_q <= ~sclkSync_q[SYNC_STAGES-2] & sclkSync_q[SYNC_STAGES-1];
            csRise_q   <= csSync_q[SYNC_STAGES-2] & ~csSync_q[SYNC_STAGES-1];
            csFall_q   <= ~csSync_q[SYNC_STAGES-2] & csSync_q[SYNC_STAGES-1];
        end
    end

    assign csS   = csSync_q[SYNC_STAGES-1];
    assign mosiS = mosiSync_q[SYNC_STAGES-1];
    // The CS chain resets high, so only trust it once every stage holds a post-reset sample.
    assign csSettledHigh = (&settle_q) & (&csSync_q);

    always_ff @(posedge CLOCK_50) begin
        if (!Reset_SPI) begin
            state_q    <= WAIT_HIGH;
            bitCnt_q   <= '0;
            overrun_q  <= 1'b0;
            rxShift_q  <= '0;
            txShift_q  <= '0;
            miso_q     <= 1'b0;
            digitSel_q <= '0;
            dispWord_q <= '0;
            setFlag_q  <= 1'b0;
            frameErr_q <= 1'b0;
            frameCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            bitCnt_q   <= bitCnt_d;
            overrun_q  <= overrun_d;
            rxShift_q  <= rxShift_d;
            txShift_q  <= txShift_d;
            miso_q     <= miso_d;
            digitSel_q <= digitSel_d;
            dispWord_q <= dispWord_d;
            setFlag_q  <= setFlag_d;
            frameErr_q <= frameErr_d;
            frameCnt_q <= frameCnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bitCnt_d   = bitCnt_q;
        overrun_d  = overrun_q;
        rxShift_d  = rxShift_q;
        txShift_d  = txShift_q;
        digitSel_d = digitSel_q;
        dispWord_d = dispWord_q;
        setFlag_d  = 1'b0;
        frameErr_d = 1'b0;
        frameCnt_d = frameCnt_q;

        case (state_q)
            WAIT_HIGH: begin
                if (csSettledHigh) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (csFall_q) begin
                    state_d   = SHIFT;
                    bitCnt_d  = '0;
                    overrun_d = 1'b0;
                    txShift_d = {5'b0, digitSel_q, dispWord_q};
                end
            end
            SHIFT: begin
                // A CS rise pre-empts any SCLK edge arriving in the same cycle.
                if (csRise_q) begin
                    if (bitCnt_q == 5'd16 && !overrun_q) begin
                        state_d = COMMIT;
                    end else begin
                        frameErr_d = 1'b1;
                        state_d    = IDLE;
                    end
                end else begin
                    if (sclkRise_q) begin
                        if (bitCnt_q == 5'd16) begin
                            overrun_d = 1'b1;
                        end else begin
                            rxShift_d = {rxShift_q[14:0], mosiS};
                            bitCnt_d  = bitCnt_q + 5'd1;
                        end
                    end
                    if (sclkFall_q) begin
                        txShift_d = {txShift_q[14:0], 1'b0};
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
                if (rxShift_q[15:8] <= ADDR_LIMIT) begin
                    digitSel_d = rxShift_q[10:8];
                    dispWord_d = rxShift_q[7:0];
                    setFlag_d  = 1'b1;
                    frameCnt_d = frameCnt_q + 8'd1;
                end else begin
                    frameErr_d = 1'b1;
                end
            end
            default: begin
                state_d = WAIT_HIGH;
            end
        endcase

        miso_d = csS ? 1'b0 : txShift_d[15];
    end

    assign SPI_MISO             = miso_q;
    assign Elite_7Seg_Digit_Sel = digitSel_q;
    assign Elite_7Seg_Disp_Word = dispWord_q;
    assign Elite_7Seg_Set_Flag  = setFlag_q;
    assign SPI_Frame_Err        = frameErr_q;
    assign SPI_Frame_Cnt        = frameCnt_q;

endmodule
